cam_cmd_ctrl: RTL and testbench

- Parametrised byte-stream command processor for the CAM array.
- It sits between the usb_uart byte pipeline and a cam instance of any NUM_BITS/NUM_CELLS.
- It parses opcode + hexadecimal argument lines, drives the CAM control lines with timed pulses, and returns hex-encoded replies, OK acknowledgements or coded errors.
- Next generation of the bench-top CAM front-end: width-generic, and adds hex I/O, backpressure, timeout and error codes.

---
 rtl/cam_cmd_pkg.sv | 71 +++++++
 rtl/cam_cmd_ctrl_reply_tx.sv | 99 +++++++++
 rtl/cam_cmd_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_cam_cmd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cmd_pkg.sv
// Shared constants, reply strings and hex helpers for the CAM command processor.
package cam_cmd_pkg;

    localparam logic [2:0] S_OP       = 3'd0;
    localparam logic [2:0] S_ARG      = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_PULSE_HI = 3'd3;
    localparam logic [2:0] S_PULSE_LO = 3'd4;
    localparam logic [2:0] S_WAIT_SET = 3'd5;
    localparam logic [2:0] S_TX       = 3'd6;

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_E  = 8'h45;

    localparam logic [7:0] OP_LOAD_CMP  = 8'h61;  // 'a'
    localparam logic [7:0] OP_READ_CMP  = 8'h62;  // 'b'
    localparam logic [7:0] OP_LOAD_MSK  = 8'h63;  // 'c'
    localparam logic [7:0] OP_READ_MSK  = 8'h64;  // 'd'
    localparam logic [7:0] OP_SEL_FIRST = 8'h65;  // 'e'
    localparam logic [7:0] OP_READ_TAGS = 8'h66;  // 'f'
    localparam logic [7:0] OP_SET_HI    = 8'h67;  // 'g'
    localparam logic [7:0] OP_SET_LO    = 8'h68;  // 'h'
    localparam logic [7:0] OP_WRITE     = 8'h69;  // 'i'
    localparam logic [7:0] OP_READ_DATA = 8'h6A;  // 'j'
    localparam logic [7:0] OP_SEARCH    = 8'h6B;  // 'k'

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_OPCODE   = 3'd1;
    localparam logic [2:0] ERR_HEX      = 3'd2;
    localparam logic [2:0] ERR_OVERFLOW = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

    localparam logic [15:0] STR_OK = 16'h4F4B;  // "OK"

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
    } hex_nib_t;

    // Letters a-f / A-F share low nibbles 1..6, so value is low nibble + 9.
    function automatic hex_nib_t hex_to_nib(input logic [7:0] b);
        hex_nib_t r;
        r.valid = 1'b0;
        r.nib   = b[3:0];
        if (b >= 8'h30 && b <= 8'h39) begin
            r.valid = 1'b1;
        end else if ((b >= 8'h61 && b <= 8'h66) || (b >= 8'h41 && b <= 8'h46)) begin
            r.valid = 1'b1;
            r.nib   = b[3:0] + 4'd9;
        end
        return r;
    endfunction

    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic op_valid(input logic [7:0] b);
        return (b >= OP_LOAD_CMP) && (b <= OP_SEARCH);
    endfunction

    function automatic logic op_has_arg(input logic [7:0] b);
        return (b == OP_LOAD_CMP) || (b == OP_LOAD_MSK);
    endfunction

    function automatic logic [15:0] err_str(input logic [2:0] code);
        return {CH_E, 8'h30 + {5'b0, code}};
    endfunction

endpackage

// File: rtl/cam_cmd_ctrl_reply_tx.sv
// Reply serialiser: streams a hex-encoded value or a two-char string, each followed by CR LF.
module cam_reply_tx
    import cam_cmd_pkg::*;
#(
    parameter int unsigned REP_W = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_val_i,
    input  logic                              load_str_i,
    input  logic [REP_W-1:0]                  val_i,
    input  logic [$clog2(REP_W/4 + 2)-1:0]    nibs_i,
    input  logic [15:0]                       str_i,
    output logic [7:0]                        tx_data_o,
    output logic                              tx_valid_o,
    input  logic                              tx_ready_i,
    output logic                              done_c
);

    localparam int unsigned CNT_W = $clog2(REP_W/4 + 2);

    logic [REP_W-1:0] val_q, val_d;
    logic             str_q, str_d;
    logic [CNT_W-1:0] plen_q, plen_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             last_c;

    // Byte at position pos: payload (chars or nibbles, MSB first), then CR, then LF.
    function automatic logic [7:0] byte_at(input logic [REP_W-1:0] val, input logic str_mode,
                                           input logic [CNT_W-1:0] plen, input logic [CNT_W-1:0] pos);
        logic [REP_W-1:0] sh;
        logic [CNT_W-1:0] idx;
        idx = plen - pos - CNT_W'(1);
        if (pos < plen) begin
            if (str_mode) begin
                sh = val >> {idx, 3'b000};
                return sh[7:0];
            end
            sh = val >> {idx, 2'b00};
            return nib_to_hex(sh[3:0]);
        end
        return (pos == plen) ? CH_CR : CH_LF;
    endfunction

    assign last_c = (pos_q == plen_q + CNT_W'(1));
    assign done_c = tx_valid_q & tx_ready_i & last_c;

    always_comb begin
        val_d      = val_q;
        str_d      = str_q;
        plen_d     = plen_q;
        pos_d      = pos_q;
        tx_valid_d = tx_valid_q;
        if (load_val_i) begin
            val_d      = val_i;
            str_d      = 1'b0;
            plen_d     = nibs_i;
            pos_d      = '0;
            tx_valid_d = 1'b1;
        end else if (load_str_i) begin
            val_d      = REP_W'(str_i);
            str_d      = 1'b1;
            plen_d     = CNT_W'(2);
            pos_d      = '0;
            tx_valid_d = 1'b1;
        end else if (tx_valid_q && tx_ready_i) begin
            if (last_c) begin
                tx_valid_d = 1'b0;
            end else begin
                pos_d = pos_q + CNT_W'(1);
            end
        end
        tx_data_d = tx_valid_d ? byte_at(val_d, str_d, plen_d, pos_d) : tx_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q      <= '0;
            str_q      <= 1'b0;
            plen_q     <= '0;
            pos_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            val_q      <= val_d;
            str_q      <= str_d;
            plen_q     <= plen_d;
            pos_q      <= pos_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;

endmodule

// File: rtl/cam_cmd_ctrl.sv
// Byte-stream command processor: parses opcode + hex argument lines and drives a CAM instance.
module cam_cmd_ctrl
    import cam_cmd_pkg::*;
#(
    parameter int unsigned NUM_BITS     = 32,
    parameter int unsigned NUM_CELLS    = 16,
    parameter int unsigned PULSE_CYCLES = 10,
    parameter int unsigned SET_TIMEOUT  = 1024
) (
    input  logic                    clk_48mhz,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [NUM_BITS-1:0]     comparand,
    output logic [NUM_BITS-1:0]     mask,
    output logic                    perform_search,
    output logic                    set,
    output logic                    select_first,
    output logic [2*NUM_BITS-1:0]   write_lines,
    input  logic [NUM_CELLS-1:0]    tag_wires,
    input  logic [NUM_BITS-1:0]     read_lines,
    output logic                    busy,
    output logic [7:0]              err_count
);

    localparam int unsigned MAX_DIG = NUM_BITS / 4;
    localparam int unsigned DIG_W   = $clog2(MAX_DIG + 1);
    localparam int unsigned WIDE_W  = (NUM_BITS > NUM_CELLS) ? NUM_BITS : NUM_CELLS;
    localparam int unsigned REP_W   = (WIDE_W > 16) ? WIDE_W : 16;
    localparam int unsigned CNT_W   = $clog2(REP_W/4 + 2);
    localparam int unsigned TMR_MAX = (PULSE_CYCLES > SET_TIMEOUT) ? PULSE_CYCLES : SET_TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    logic [2:0]            state_q, state_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [NUM_BITS-1:0]   arg_q, arg_d;
    logic [DIG_W-1:0]      ndig_q, ndig_d;
    logic [2:0]            err_q, err_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [NUM_BITS-1:0]   comparand_q, comparand_d;
    logic [NUM_BITS-1:0]   mask_q, mask_d;
    logic [2*NUM_BITS-1:0] wl_q, wl_d, wl_calc;
    logic                  set_q, set_d;
    logic                  search_q, search_d;
    logic                  selfirst_q, selfirst_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  busy_q, busy_d;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  rx_fire;
    hex_nib_t              nib;
    logic                  load_val, load_str, tx_done;
    logic [REP_W-1:0]      rep_val;
    logic [CNT_W-1:0]      rep_nibs;
    logic [15:0]           rep_str;

    assign rx_fire = rx_valid & rx_ready_q;
    assign nib     = hex_to_nib(rx_data);

    // Two write-line rails per bit: drive-1 on the even rail, drive-0 on the odd rail.
    always_comb begin
        wl_calc = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            wl_calc[2*i]   = comparand_q[i] & mask_q[i];
            wl_calc[2*i+1] = ~comparand_q[i] & mask_q[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        arg_d       = arg_q;
        ndig_d      = ndig_q;
        err_d       = err_q;
        tmr_d       = tmr_q;
        comparand_d = comparand_q;
        mask_d      = mask_q;
        wl_d        = wl_q;
        set_d       = set_q;
        search_d    = search_q;
        selfirst_d  = selfirst_q;
        err_cnt_d   = err_cnt_q;
        load_val    = 1'b0;
        load_str    = 1'b0;
        rep_val     = '0;
        rep_nibs    = '0;
        rep_str     = STR_OK;

        case (state_q)
            S_OP: begin
                if (rx_fire && rx_data != CH_CR && rx_data != CH_LF) begin
                    opcode_d = rx_data;
                    arg_d    = '0;
                    ndig_d   = '0;
                    err_d    = op_valid(rx_data) ? ERR_NONE : ERR_OPCODE;
                    state_d  = S_ARG;
                end
            end
            // Once an error is flagged, everything up to CR is drained unchanged.
            S_ARG: begin
                if (rx_fire) begin
                    if (rx_data == CH_CR) begin
                        state_d = S_EXEC;
                    end else if (rx_data == CH_LF || err_q != ERR_NONE) begin
                        state_d = S_ARG;
                    end else if (!op_has_arg(opcode_q) || !nib.valid) begin
                        err_d = ERR_HEX;
                    end else if (ndig_q == DIG_W'(MAX_DIG)) begin
                        err_d = ERR_OVERFLOW;
                    end else begin
                        arg_d  = {arg_q[NUM_BITS-5:0], nib.nib};
                        ndig_d = ndig_q + DIG_W'(1);
                    end
                end
            end
            S_EXEC: begin
                state_d = S_TX;
                if (err_q != ERR_NONE) begin
                    load_str = 1'b1;
                    rep_str  = err_str(err_q);
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                end else begin
                    case (opcode_q)
                        OP_LOAD_CMP:  begin comparand_d = arg_q; load_str = 1'b1; end
                        OP_LOAD_MSK:  begin mask_d = arg_q; load_str = 1'b1; end
                        OP_SET_LO:    begin set_d = 1'b0; load_str = 1'b1; end
                        OP_WRITE:     begin wl_d = wl_calc; load_str = 1'b1; end
                        OP_READ_CMP: begin
                            load_val = 1'b1;
                            rep_val  = REP_W'(comparand_q);
                            rep_nibs = CNT_W'(NUM_BITS/4);
                        end
                        OP_READ_MSK: begin
                            load_val = 1'b1;
                            rep_val  = REP_W'(mask_q);
                            rep_nibs = CNT_W'(NUM_BITS/4);
                        end
                        OP_READ_TAGS: begin
                            load_val = 1'b1;
                            rep_val  = REP_W'(tag_wires);
                            rep_nibs = CNT_W'(NUM_CELLS/4);
                        end
                        OP_READ_DATA: begin
                            load_val = 1'b1;
                            rep_val  = REP_W'(read_lines);
                            rep_nibs = CNT_W'(NUM_BITS/4);
                        end
                        OP_SEL_FIRST: begin selfirst_d = 1'b1; tmr_d = '0; state_d = S_PULSE_HI; end
                        OP_SEARCH:    begin search_d = 1'b1; tmr_d = '0; state_d = S_PULSE_HI; end
                        OP_SET_HI:    begin set_d = 1'b1; tmr_d = '0; state_d = S_WAIT_SET; end
                        default: begin
                            load_str = 1'b1;
                            rep_str  = err_str(ERR_OPCODE);
                        end
                    endcase
                end
            end
            S_PULSE_HI: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(PULSE_CYCLES - 1)) begin
                    search_d   = 1'b0;
                    selfirst_d = 1'b0;
                    tmr_d      = '0;
                    state_d    = S_PULSE_LO;
                end
            end
            S_PULSE_LO: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q == TMR_W'(PULSE_CYCLES - 1)) begin
                    load_str = 1'b1;
                    state_d  = S_TX;
                end
            end
            // Timeout leaves set high; only an explicit 'h' clears it.
            S_WAIT_SET: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (&tag_wires) begin
                    load_str = 1'b1;
                    state_d  = S_TX;
                end else if (tmr_q == TMR_W'(SET_TIMEOUT - 1)) begin
                    load_str = 1'b1;
                    rep_str  = err_str(ERR_TIMEOUT);
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    state_d  = S_TX;
                end
            end
            S_TX: begin
                if (tx_done) state_d = S_OP;
            end
            default: state_d = S_OP;
        endcase

        rx_ready_d = (state_d == S_OP) || (state_d == S_ARG);
        busy_d     = (state_d != S_OP);
    end

    always_ff @(posedge clk_48mhz or posedge reset) begin
        if (reset) begin
            state_q     <= S_OP;
            opcode_q    <= '0;
            arg_q       <= '0;
            ndig_q      <= '0;
            err_q       <= ERR_NONE;
            tmr_q       <= '0;
            comparand_q <= '0;
            mask_q      <= '0;
            wl_q        <= '0;
            set_q       <= 1'b0;
            search_q    <= 1'b0;
            selfirst_q  <= 1'b0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            arg_q       <= arg_d;
            ndig_q      <= ndig_d;
            err_q       <= err_d;
            tmr_q       <= tmr_d;
            comparand_q <= comparand_d;
            mask_q      <= mask_d;
            wl_q        <= wl_d;
            set_q       <= set_d;
            search_q    <= search_d;
            selfirst_q  <= selfirst_d;
            rx_ready_q  <= rx_ready_d;
            busy_q      <= busy_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    cam_reply_tx #(.REP_W(REP_W)) u_reply_tx (
        .clk        (clk_48mhz),
        .rst        (reset),
        .load_val_i (load_val),
        .load_str_i (load_str),
        .val_i      (rep_val),
        .nibs_i     (rep_nibs),
        .str_i      (rep_str),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .done_c     (tx_done)
    );

    assign rx_ready       = rx_ready_q;
    assign busy           = busy_q;
    assign comparand      = comparand_q;
    assign mask           = mask_q;
    assign write_lines    = wl_q;
    assign set            = set_q;
    assign perform_search = search_q;
    assign select_first   = selfirst_q;
    assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Scoreboard bench for cam_cmd_ctrl: expected reply bytes are queued per command and popped as tx bytes leave.
module tb_cam_cmd_ctrl;

    localparam int unsigned NB = 32;
    localparam int unsigned NC = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [NB-1:0]   comparand;
    logic [NB-1:0]   mask;
    logic            perform_search;
    logic            set;
    logic            select_first;
    logic [2*NB-1:0] write_lines;
    logic [NC-1:0]   tag_wires;
    logic [NB-1:0]   read_lines;
    logic            busy;
    logic [7:0]      err_count;

    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         exp_err  = 0;

    always #10 clk = ~clk;

    cam_cmd_ctrl #(
        .NUM_BITS(NB), .NUM_CELLS(NC), .PULSE_CYCLES(10), .SET_TIMEOUT(1024)
    ) dut (
        .clk_48mhz(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .comparand(comparand), .mask(mask), .perform_search(perform_search),
        .set(set), .select_first(select_first), .write_lines(write_lines),
        .tag_wires(tag_wires), .read_lines(read_lines),
        .busy(busy), .err_count(err_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // Reply scoreboard: every consumed tx byte must match the oldest queued byte.
    always @(negedge clk) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                check("tx_extra_byte", 64'(tx_data), 64'h100);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("tx_byte", 64'(tx_data), 64'(e));
            end
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        check("rx_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_line(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Cycles from the CR-accept cycle n to the first cycle with tx_valid high.
    task automatic get_lat(output int lat);
        lat = -1;
        for (int j = 1; j <= 2000 && lat < 0; j++) begin
            @(negedge clk);
            if (tx_valid) lat = j;
        end
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !tx_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic cmd(input string s, input string reply, input string tag);
        push_str(reply);
        send_line(s);
        wait_idle(tag);
    endtask

    task automatic pulse_check(input string s, input bit is_search, input string tag);
        int first, hi, lat;
        bit rdy_seen, line;
        first = -1; hi = 0; lat = -1; rdy_seen = 1'b0;
        push_str("OK\r\n");
        send_line(s);
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            line = is_search ? perform_search : select_first;
            if (line) begin
                if (first < 0) first = j;
                hi++;
            end
            if (j <= 21 && rx_ready) rdy_seen = 1'b1;
            if (tx_valid && lat < 0) lat = j;
        end
        check({tag, "_first"}, 64'(first), 64'd2);
        check({tag, "_width"}, 64'(hi), 64'd10);
        check({tag, "_rx_ready"}, 64'(rdy_seen), 64'd0);
        check({tag, "_ok_lat"}, 64'(lat), 64'd22);
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        #1200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int lat, unstable;
        logic [7:0] d0;
        reset = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b1;
        tag_wires = '0; read_lines = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", 64'(rx_ready), 64'd0);
        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outputs", {32'(comparand | mask), 24'd0, err_count},  64'd0);
        check("rst_lines", 64'({perform_search, select_first, set}), 64'd0);
        check("rst_write_lines", write_lines, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_rx_ready_rise", 64'(rx_ready), 64'd1);

        // Load + read back comparand, with reply latency.
        cmd("a1F\r", "OK\r\n", "load_cmp");
        check("cmp_1f", 64'(comparand), 64'h1F);
        push_str("0000001F\r\n");
        send_line("b\r");
        get_lat(lat);
        check("read_lat", 64'(lat), 64'd2);
        wait_idle("read_cmp");

        // Overflow leaves mask untouched.
        cmd("c123456789\r", "E3\r\n", "mask_ovf");
        exp_err++;
        check("mask_ovf_keep", 64'(mask), 64'd0);
        check("err_cnt_1", 64'(err_count), 64'(exp_err));

        pulse_check("k\r", 1'b1, "search");
        pulse_check("e\r", 1'b0, "selfirst");

        // Set timeout, then a set that sees all tags.
        tag_wires = 16'h7FFF;
        push_str("E4\r\n");
        send_line("g\r");
        get_lat(lat);
        check("set_timeout_lat", 64'(lat), 64'd1026);
        wait_idle("set_timeout");
        exp_err++;
        check("set_timeout_set", 64'(set), 64'd1);
        check("err_cnt_2", 64'(err_count), 64'(exp_err));
        cmd("h\r", "OK\r\n", "set_lo");
        check("set_lo_val", 64'(set), 64'd0);
        tag_wires = 16'hFFFF;
        push_str("OK\r\n");
        send_line("g\r");
        get_lat(lat);
        check("set_ok_lat", 64'(lat), 64'd3);
        wait_idle("set_ok");
        check("set_ok_val", 64'(set), 64'd1);
        cmd("h\r", "OK\r\n", "set_lo2");

        tag_wires = 16'h1234;
        cmd("f\r", "1234\r\n", "read_tags");

        // Write-line encoding for comparand A5 under mask 0F.
        cmd("c0F\r", "OK\r\n", "mask_0f");
        cmd("aA5\r", "OK\r\n", "cmp_a5");
        cmd("i\r", "OK\r\n", "write");
        check("write_lines", write_lines, 64'h99);
        cmd("d\r", "0000000F\r\n", "read_mask");

        // Error replies.
        cmd("z\r", "E1\r\n", "bad_opcode");
        cmd("aG\r", "E2\r\n", "bad_hex");
        check("bad_hex_keep", 64'(comparand), 64'hA5);
        cmd("b5\r", "E2\r\n", "unexpected_arg");
        exp_err += 3;
        check("err_cnt_5", 64'(err_count), 64'(exp_err));

        // Argument corner cases.
        cmd("a\r", "OK\r\n", "zero_digits");
        check("zero_digits_val", 64'(comparand), 64'd0);
        cmd("aabcdef01\r", "OK\r\n", "lower_hex");
        check("lower_hex_val", 64'(comparand), 64'hABCDEF01);
        cmd("b\r", "ABCDEF01\r\n", "upper_reply");
        cmd("c\n5\r", "OK\r\n", "lf_ignored");
        check("lf_ignored_val", 64'(mask), 64'd5);
        send_byte(8'h0D);
        repeat (6) @(negedge clk);
        check("lone_cr_silent", 64'({busy, tx_valid}), 64'd0);

        // err_count saturation.
        for (int i = 0; i < 256; i++) cmd("x\r", "E1\r\n", "sat_err");
        check("err_cnt_sat", 64'(err_count), 64'd255);

        // Backpressure: reply held stable while tx_ready is low.
        read_lines = 32'hDEADBEEF;
        tx_ready = 1'b0;
        push_str("DEADBEEF\r\n");
        send_line("j\r");
        get_lat(lat);
        check("bp_lat", 64'(lat), 64'd2);
        d0 = tx_data;
        unstable = 0;
        repeat (50) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== d0) unstable++;
        end
        check("bp_stable", 64'(unstable), 64'd0);
        check("bp_first_byte", 64'(d0), 64'h44);
        @(posedge clk);
        #1;
        tx_ready = 1'b1;
        wait_idle("bp_reply");

        // Reset in the middle of a stalled reply.
        tx_ready = 1'b0;
        send_line("j\r");
        get_lat(lat);
        check("rst_mid_lat", 64'(lat), 64'd2);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_tx_valid", 64'(tx_valid), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_rel_rx_ready0", 64'(rx_ready), 64'd0);
        @(posedge clk);
        #1;
        check("rst_rel_rx_ready1", 64'(rx_ready), 64'd1);
        check("rst_rel_busy", 64'(busy), 64'd0);
        check("rst_rel_err", 64'(err_count), 64'd0);
        tx_ready = 1'b1;
        cmd("b\r", "00000000\r\n", "post_reset_read");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
